// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the Lab 6 program sequencer.
// The instruction word layout is [1:0] op, [4:2] X, [7:5] Y.
package prog_seq_pkg;

    localparam int OPW   = 2;
    localparam int REGW  = 3;
    localparam int WORDW = OPW + 2 * REGW;

    localparam logic [OPW-1:0] OP_MV  = 2'b00;
    localparam logic [OPW-1:0] OP_MVI = 2'b01;
    localparam logic [OPW-1:0] OP_ADD = 2'b10;
    localparam logic [OPW-1:0] OP_SUB = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_HALT,
        S_FAULT
    } state_t;

    function automatic logic [OPW-1:0] op_of(input logic [WORDW-1:0] word);
        return word[OPW-1:0];
    endfunction

endpackage

// File: rtl/prog_sequencer_rise_detect.sv
// One-flop synchronous rising-edge detector: rise is high in the cycle
// where d is 1 and was 0 in the previous cycle.
module rise_detect (
    input  logic CLK_1HZ,
    input  logic resetn,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge CLK_1HZ) begin
        if (!resetn) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer feeding the Lab 6 processor over a run/done handshake.
// Optional watchdog on WAIT is enabled by defining PROG_SEQ_WATCHDOG_EN.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             CLK_1HZ,
    input  logic             resetn,
    input  logic             load_en,
    input  logic             load_we,
    input  logic [WORDW-1:0] load_data,
    input  logic             start,
    input  logic             done,
    output logic [WORDW-1:0] ir_out,
    output logic [WORDW-1:0] din_out,
    output logic             run,
    output logic [AW-1:0]    pc,
    output logic [AW:0]      prog_len,
    output logic             busy,
    output logic             halted,
    output logic             full,
    output logic             fault,
    output state_t           state_dbg
);

    // Handshake: the processor sees run high for exactly one cycle with
    // ir_out/din_out already valid; it answers with a rising edge on done,
    // which is only honoured once the sequencer has moved to WAIT.

    if (DEPTH != (1 << AW) || TIMEOUT < 1) begin : g_bad_params
        $error("prog_sequencer: DEPTH must equal 2**AW and TIMEOUT must be positive");
    end

    logic load_we_rise;
    logic start_rise;
    logic done_rise;

    rise_detect u_we_edge (
        .CLK_1HZ (CLK_1HZ),
        .resetn  (resetn),
        .d       (load_we),
        .rise    (load_we_rise)
    );

    rise_detect u_start_edge (
        .CLK_1HZ (CLK_1HZ),
        .resetn  (resetn),
        .d       (start),
        .rise    (start_rise)
    );

    rise_detect u_done_edge (
        .CLK_1HZ (CLK_1HZ),
        .resetn  (resetn),
        .d       (done),
        .rise    (done_rise)
    );

    logic [WORDW-1:0] mem [DEPTH];
    state_t           state;
    logic [AW:0]      pc_q;
    logic [AW:0]      step_pc;
    logic [AW:0]      issue_addr;
    logic [AW:0]      next_addr;
    logic [WORDW-1:0] issue_ir;
    logic [WORDW-1:0] issue_din;
    logic             mem_write;

    assign pc        = pc_q[AW-1:0];
    assign state_dbg = state;
    assign mem_write = (state == S_LOAD) && load_we_rise && !full;
    assign step_pc   = pc_q + ((op_of(ir_out) == OP_MVI) ? (AW+1)'(2) : (AW+1)'(1));

    // Memory is deliberately not cleared; prog_len=0 hides stale words.
    always_ff @(posedge CLK_1HZ) begin
        if (mem_write) begin
            mem[prog_len[AW-1:0]] <= load_data;
        end
    end

    // Word issued next: address 0 on a fresh start, the stepped pc from WAIT.
    always_comb begin
        issue_addr = (state == S_WAIT) ? step_pc : '0;
        next_addr  = issue_addr + (AW+1)'(1);
        issue_ir   = mem[issue_addr[AW-1:0]];
        issue_din  = '0;
        if (op_of(issue_ir) == OP_MVI && next_addr < prog_len) begin
            issue_din = mem[next_addr[AW-1:0]];
        end
    end

`ifdef PROG_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;
    logic           fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge CLK_1HZ) begin
        if (!resetn) begin
            state    <= S_IDLE;
            ir_out   <= '0;
            din_out  <= '0;
            run      <= 1'b0;
            pc_q     <= '0;
            prog_len <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            full     <= 1'b0;
`ifdef PROG_SEQ_WATCHDOG_EN
            wd_cnt   <= '0;
            fault_q  <= 1'b0;
`endif
        end else begin
            run <= 1'b0;

            if (mem_write) begin
                prog_len <= prog_len + (AW+1)'(1);
                full     <= (prog_len + (AW+1)'(1)) == (AW+1)'(DEPTH);
            end

            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        state <= S_LOAD;
                    end else if (start_rise && prog_len != '0) begin
                        pc_q    <= '0;
                        state   <= S_ISSUE;
                        run     <= 1'b1;
                        busy    <= 1'b1;
                        ir_out  <= issue_ir;
                        din_out <= issue_din;
                    end
                end

                S_LOAD: begin
                    if (!load_en) begin
                        state <= S_IDLE;
                    end
                end

                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef PROG_SEQ_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end

                S_WAIT: begin
                    if (done_rise) begin
                        pc_q <= step_pc;
                        if (step_pc >= prog_len) begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state   <= S_ISSUE;
                            run     <= 1'b1;
                            ir_out  <= issue_ir;
                            din_out <= issue_din;
                        end
                    end
`ifdef PROG_SEQ_WATCHDOG_EN
                    else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                        state   <= S_FAULT;
                        busy    <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
`endif
                end

                S_HALT: begin
                    if (start_rise) begin
                        state  <= S_IDLE;
                        halted <= 1'b0;
                    end
                end

`ifdef PROG_SEQ_WATCHDOG_EN
                S_FAULT: begin
                    state <= S_FAULT;
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: a cycle-by-cycle vector table plus
// hand-written sequences for reset, full memory, mvi tail and watchdog.
module tb_prog_sequencer;

    logic       CLK_1HZ = 1'b0;
    logic       resetn;
    logic       load_en;
    logic       load_we;
    logic [7:0] load_data;
    logic       start;
    logic       done;
    logic [7:0] ir_out;
    logic [7:0] din_out;
    logic       run;
    logic [3:0] pc;
    logic [4:0] prog_len;
    logic       busy;
    logic       halted;
    logic       full;
    logic       fault;
    prog_seq_pkg::state_t state_dbg;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {pc, ir_out, din_out} expected at each run pulse.
    logic [19:0] exp_q[$];

    prog_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(8)) dut (
        .CLK_1HZ   (CLK_1HZ),
        .resetn    (resetn),
        .load_en   (load_en),
        .load_we   (load_we),
        .load_data (load_data),
        .start     (start),
        .done      (done),
        .ir_out    (ir_out),
        .din_out   (din_out),
        .run       (run),
        .pc        (pc),
        .prog_len  (prog_len),
        .busy      (busy),
        .halted    (halted),
        .full      (full),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    always #5 CLK_1HZ = ~CLK_1HZ;

    typedef struct {
        logic       le;
        logic       we;
        logic [7:0] data;
        logic       st;
        logic       dn;
        logic [7:0] ir;
        logic [7:0] din;
        logic       run;
        logic [3:0] pc;
        logic [4:0] len;
        logic       busy;
        logic       halted;
        logic       full;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic le, input logic we, input logic [7:0] data,
                                input logic st, input logic dn, input logic [7:0] ir,
                                input logic [7:0] din, input logic r, input logic [3:0] p,
                                input logic [4:0] len, input logic b, input logic h,
                                input logic f);
        vec_t v;
        v.le = le; v.we = we; v.data = data; v.st = st; v.dn = dn;
        v.ir = ir; v.din = din; v.run = r; v.pc = p; v.len = len;
        v.busy = b; v.halted = h; v.full = f;
        return v;
    endfunction

    task automatic step();
        @(negedge CLK_1HZ);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ir"}, 32'(ir_out), 0);
        chk({tag, "_din"}, 32'(din_out), 0);
        chk({tag, "_run"}, 32'(run), 0);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_len"}, 32'(prog_len), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0; load_en = 1'b0; load_we = 1'b0; load_data = 8'h00;
        start = 1'b0; done = 1'b0;
        step();
        step();
        chk_all_zero(tag);
        resetn = 1'b1;
    endtask

    task automatic load_word(input logic [7:0] d);
        load_data = d;
        load_we = 1'b1;
        step();
        load_we = 1'b0;
        step();
    endtask

    // Starts the loaded program and answers every run pulse with a done edge
    // two cycles later, comparing each issue against the scoreboard.
    task automatic run_prog(input string tag, input int budget, output int runs);
        logic [19:0] e;
        runs = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < budget && !halted; c++) begin
            if (run) begin
                runs++;
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_run"}, 32'(runs), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s_issue%0d", tag, runs), {12'h0, pc, ir_out, din_out}, 32'(e));
                end
                step();
                done = 1'b1;
                step();
                done = 1'b0;
            end else begin
                step();
            end
        end
        chk({tag, "_halted"}, 32'(halted), 1);
        chk({tag, "_exp_left"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        int runs;

        do_reset("reset");

        tbl.push_back(mk(1,0,8'h00,0,0, 8'h00,8'h00,0,4'd0,5'd0,0,0,0));
        tbl.push_back(mk(1,1,8'h01,0,0, 8'h00,8'h00,0,4'd0,5'd1,0,0,0));
        tbl.push_back(mk(1,0,8'h00,0,0, 8'h00,8'h00,0,4'd0,5'd1,0,0,0));
        tbl.push_back(mk(1,1,8'h3C,0,0, 8'h00,8'h00,0,4'd0,5'd2,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 8'h00,8'h00,0,4'd0,5'd2,0,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 8'h01,8'h3C,1,4'd0,5'd2,1,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 8'h01,8'h3C,0,4'd0,5'd2,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 8'h01,8'h3C,0,4'd0,5'd2,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1, 8'h01,8'h3C,0,4'd2,5'd2,0,1,0));
        tbl.push_back(mk(1,0,8'h00,0,0, 8'h01,8'h3C,0,4'd2,5'd2,0,1,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 8'h01,8'h3C,0,4'd2,5'd2,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 8'h01,8'h3C,0,4'd2,5'd2,0,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 8'h01,8'h3C,1,4'd0,5'd2,1,0,0));
        tbl.push_back(mk(0,0,8'h00,1,1, 8'h01,8'h3C,0,4'd0,5'd2,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1, 8'h01,8'h3C,0,4'd0,5'd2,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 8'h01,8'h3C,0,4'd0,5'd2,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1, 8'h01,8'h3C,0,4'd2,5'd2,0,1,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 8'h01,8'h3C,0,4'd2,5'd2,0,1,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 8'h01,8'h3C,0,4'd2,5'd2,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 8'h01,8'h3C,0,4'd2,5'd2,0,0,0));
        tbl.push_back(mk(1,0,8'h00,1,0, 8'h01,8'h3C,0,4'd2,5'd2,0,0,0));
        tbl.push_back(mk(0,1,8'h0A,0,0, 8'h01,8'h3C,0,4'd2,5'd3,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 8'h01,8'h3C,0,4'd2,5'd3,0,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 8'h01,8'h3C,1,4'd0,5'd3,1,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 8'h01,8'h3C,0,4'd0,5'd3,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1, 8'h0A,8'h00,1,4'd2,5'd3,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1, 8'h0A,8'h00,0,4'd2,5'd3,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 8'h0A,8'h00,0,4'd2,5'd3,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1, 8'h0A,8'h00,0,4'd3,5'd3,0,1,0));

        foreach (tbl[i]) begin
            load_en = tbl[i].le; load_we = tbl[i].we; load_data = tbl[i].data;
            start = tbl[i].st; done = tbl[i].dn;
            step();
            chk($sformatf("vec%0d_ir", i), 32'(ir_out), 32'(tbl[i].ir));
            chk($sformatf("vec%0d_din", i), 32'(din_out), 32'(tbl[i].din));
            chk($sformatf("vec%0d_run", i), 32'(run), 32'(tbl[i].run));
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("vec%0d_len", i), 32'(prog_len), 32'(tbl[i].len));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(tbl[i].halted));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].full));
            chk($sformatf("vec%0d_fault", i), 32'(fault), 0);
        end

        // Three add words: three issues at pc 0, 1, 2 then HALT at pc 3.
        do_reset("reset_add");
        load_en = 1'b1;
        step();
        load_word(8'h0A);
        load_word(8'h2E);
        load_word(8'h56);
        load_en = 1'b0;
        step();
        exp_q.push_back({4'd0, 8'h0A, 8'h00});
        exp_q.push_back({4'd1, 8'h2E, 8'h00});
        exp_q.push_back({4'd2, 8'h56, 8'h00});
        run_prog("add3", 40, runs);
        chk("add3_runs", 32'(runs), 3);
        chk("add3_pc", 32'(pc), 3);

        // Seventeen writes into a 16-word memory: the last one is dropped.
        do_reset("reset_full");
        load_en = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            load_word((i < 16) ? 8'(i << 2) : 8'hFF);
        end
        load_en = 1'b0;
        step();
        chk("full_len", 32'(prog_len), 16);
        chk("full_flag", 32'(full), 1);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({4'(i), 8'(i << 2), 8'h00});
        end
        run_prog("full16", 80, runs);
        chk("full16_runs", 32'(runs), 16);
        chk("full16_len_after", 32'(prog_len), 16);

        // mvi as the only word: stale mem[1] must not appear on din_out.
        do_reset("reset_mvi");
        load_en = 1'b1;
        step();
        load_word(8'h01);
        load_en = 1'b0;
        step();
        exp_q.push_back({4'd0, 8'h01, 8'h00});
        run_prog("mvi_last", 20, runs);
        chk("mvi_last_runs", 32'(runs), 1);
        chk("mvi_last_pc", 32'(pc), 2);

        // Reset while ISSUE is active.
        do_reset("reset_mid");
        load_en = 1'b1;
        step();
        load_word(8'h0A);
        load_en = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("mid_issue_run", 32'(run), 1);
        resetn = 1'b0;
        start = 1'b0;
        step();
        chk_all_zero("mid_after_reset");
        chk("mid_state", 32'(state_dbg), 32'(prog_seq_pkg::S_IDLE));
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            done = ~i[0];
            step();
            chk($sformatf("mid_quiet%0d_run", i), 32'(run), 0);
            chk($sformatf("mid_quiet%0d_busy", i), 32'(busy), 0);
        end
        start = 1'b0;
        done = 1'b0;

`ifdef PROG_SEQ_WATCHDOG_EN
        do_reset("reset_wd");
        load_en = 1'b1;
        step();
        load_word(8'h0A);
        load_en = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wd_issue_run", 32'(run), 1);
        step();
        chk("wd_wait_busy", 32'(busy), 1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("wd_early%0d_fault", i), 32'(fault), 0);
        end
        step();
        chk("wd_trip_fault", 32'(fault), 1);
        chk("wd_trip_run", 32'(run), 0);
        done = 1'b1;
        start = 1'b1;
        step();
        step();
        chk("wd_sticky_fault", 32'(fault), 1);
        chk("wd_sticky_run", 32'(run), 0);
        done = 1'b0;
        start = 1'b0;
        do_reset("reset_wd_clear");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
